// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the 4-digit display mux.
// Digit and overflow outputs update only at the done edge, so the display never sees a partial result.
module bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       dig0,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic [3:0]       dig3,
  output logic [1:0]       dbg_state_o
);

  localparam int CNT_W = (BIN_W <= 2) ? 1 : $clog2(BIN_W);
  localparam int SR_W  = BIN_W + 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] CLAMP_V  = BIN_W'(9999);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [SR_W-1:0]  adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_next_q, ovf_next_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [15:0]      dig_q, dig_d;
  logic             bin_ovf;

  // Comparison done at 32 bits so narrow BIN_W builds simply never overflow.
  assign bin_ovf = ({{(32-BIN_W){1'b0}}, bin} > 32'd9999);

  always_comb begin
    adj = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_q[BIN_W+4*i +: 4] >= 4'd5) begin
        adj[BIN_W+4*i +: 4] = sr_q[BIN_W+4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_next_d = ovf_next_q;
    ovf_d      = ovf_q;
    dig_d      = dig_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d       = {16'd0, (bin_ovf ? CLAMP_V : bin)};
          cnt_d      = '0;
          ovf_next_d = bin_ovf;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d  = adj << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        dig_d   = sr_q[SR_W-1 -: 16];
        ovf_d   = ovf_next_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      dig_q      <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_next_q <= ovf_next_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      dig_q      <= dig_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign ovf         = ovf_q;
  assign dig3        = dig_q[15:12];
  assign dig2        = dig_q[11:8];
  assign dig1        = dig_q[7:4];
  assign dig0        = dig_q[3:0];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, bounds, overflow clamp, reset abort, busy-ignore, back-to-back.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  dig0, dig1, dig2, dig3;
  logic [1:0]  dbg_state;
  logic [15:0] digs;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  bin2bcd_seq #(.BIN_W(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .dig0       (dig0),
    .dig1       (dig1),
    .dig2       (dig2),
    .dig3       (dig3),
    .dbg_state_o(dbg_state)
  );

  assign digs = {dig3, dig2, dig1, dig0};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  // Pulse start for one cycle, then measure latency, busy length, result and done width.
  task automatic convert(input string tag, input logic [13:0] v,
                         input logic [15:0] exp_dig, input logic exp_ovf);
    int n;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
    n        = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) busy_cnt++;
    end
    check({tag, " latency"}, n, 15);
    check({tag, " busy_cycles"}, busy_cnt, 15);
    check({tag, " digits"}, {16'd0, digs}, {16'd0, exp_dig});
    check({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    @(posedge clk);
    #1;
    check({tag, " done_width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int done_seen;
    logic [13:0] rv;
    logic [15:0] e;

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset ovf", {31'd0, ovf}, 32'd0);
    check("reset digits", {16'd0, digs}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T2 basic
    convert("t2_1234", 14'd1234, 16'h1234, 1'b0);

    // Overflow so the reset test below sees nonzero state cleared
    convert("t4_12000", 14'd12000, 16'h9999, 1'b1);

    // T1 reset mid-conversion
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd1234;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t1 busy", {31'd0, busy}, 32'd0);
    check("t1 done", {31'd0, done}, 32'd0);
    check("t1 ovf", {31'd0, ovf}, 32'd0);
    check("t1 digits", {16'd0, digs}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    done_seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("t1 no_done", done_seen, 0);

    // T3 bounds
    convert("t3_0", 14'd0, 16'h0000, 1'b0);
    convert("t3_9999", 14'd9999, 16'h9999, 1'b0);
    convert("t3_5", 14'd5, 16'h0005, 1'b0);
    convert("t3_10000", 14'd10000, 16'h9999, 1'b1);

    // T4 overflow then clear
    convert("t4b_12000", 14'd12000, 16'h9999, 1'b1);
    convert("t4b_42", 14'd42, 16'h0042, 1'b0);

    // T5 start during busy ignored
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd1234;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    bin   = 14'd8765;
    @(negedge clk);
    start = 1'b0;
    check("t5 hold_digits", {16'd0, digs}, 32'h0042);
    check("t5 busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5 digits", {16'd0, digs}, 32'h1234);
    done_seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("t5 no_second_done", done_seen, 0);
    check("t5 idle", {31'd0, busy}, 32'd0);

    // T6 back-to-back with start held high
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd1234;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t6 first_digits", {16'd0, digs}, 32'h1234);
    bin = 14'd4321;
    n   = 0;
    @(posedge clk);
    #1;
    n++;
    check("t6 done_drops", {31'd0, done}, 32'd0);
    check("t6 busy_again", {31'd0, busy}, 32'd1);
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check("t6 spacing", n, 16);
    check("t6 second_digits", {16'd0, digs}, 32'h4321);
    @(posedge clk);
    #1;
    check("t6 stop", {31'd0, busy}, 32'd0);

    // Random scoreboard
    for (int i = 0; i < 10; i++) begin
      rv = 14'($urandom_range(0, 16383));
      exp_q.push_back(bcd_of(int'(rv)));
      e = exp_q.pop_front();
      convert($sformatf("rand_%0d", rv), rv, e, (rv > 14'd9999));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
